// File: rtl/conv2d_kxk_engine.sv
// KxK fixed-point convolution engine: loads a kernel column by column, keeps a
// sliding window of accepted pixel columns and emits one rounded, saturated pixel per window.
module conv2d_kxk_engine #(
  parameter int KS        = 3,
  parameter int NB_PIX    = 8,
  parameter int NBF_PIX   = 7,
  parameter int NB_COEFF  = 8,
  parameter int NBF_COEFF = 7,
  parameter int NB_OUT    = 8,
  parameter int NBF_OUT   = 7,
  parameter int ROUND     = 1
) (
  input  logic                     clk,
  input  logic                     i_nrst,
  input  logic                     i_load_knl,
  input  logic                     i_en_conv,
  input  logic                     i_line_start,
  input  logic                     i_col_valid,
  output logic                     o_col_ready,
  input  logic [KS*NB_PIX-1:0]     i_col,
  output logic                     o_knl_loaded,
  output logic [NB_OUT-1:0]        o_pixel,
  output logic                     o_valid
);

  localparam int NB_PROD  = NB_PIX + NB_COEFF;
  localparam int NBF_PROD = NBF_PIX + NBF_COEFF;
  localparam int NB_ADD   = NB_PROD + $clog2(KS*KS);
  localparam int D        = NBF_PROD - NBF_OUT;
  localparam int NB_W     = (NB_ADD + 1 > NB_OUT + 1) ? NB_ADD + 1 : NB_OUT + 1;
  localparam int FW       = $clog2(KS + 1);
  localparam int LW       = $clog2(KS);

  localparam logic signed [NB_W-1:0] MAX_OUT =
    $signed({{(NB_W-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}});
  localparam logic signed [NB_W-1:0] MIN_OUT =
    $signed({{(NB_W-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                        state_reg;
  logic                          col_ready_reg;
  logic                          knl_loaded_reg;
  logic [LW-1:0]                 load_cnt_reg;
  logic [FW-1:0]                 fill_reg;
  logic [FW-1:0]                 fill_next;
  logic                          accept;
  logic                          load_acc;
  logic                          run_acc;
  logic                          win_done;
  logic [KS*KS*NB_COEFF-1:0]     knl_reg;
  logic [KS*KS*NB_PIX-1:0]       win_reg;
  logic [KS*KS*NB_PROD-1:0]      prod_flat;
  logic                          win_valid_reg;
  logic                          prod_valid_reg;
  logic signed [NB_ADD-1:0]      sum_acc;
  logic signed [NB_W-1:0]        sum_ext;
  logic signed [NB_W-1:0]        sum_rnd;
  logic signed [NB_W-1:0]        sum_shift;
  logic [NB_OUT-1:0]             sat_val;
  logic [NB_OUT-1:0]             pixel_reg;
  logic                          valid_reg;

  assign accept   = i_col_valid && col_ready_reg;
  assign load_acc = accept && (state_reg == LOAD);
  assign run_acc  = accept && (state_reg == RUN);

  // Line start restarts the window with the accepted column as its only column.
  always_comb begin
    fill_next = fill_reg;
    if (i_line_start)
      fill_next = FW'(1);
    else if (fill_reg != FW'(KS))
      fill_next = fill_reg + 1'b1;
  end

  assign win_done = run_acc && (fill_next == FW'(KS));

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg      <= IDLE;
      col_ready_reg  <= 1'b0;
      knl_loaded_reg <= 1'b0;
      load_cnt_reg   <= '0;
      fill_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_load_knl) begin
            state_reg      <= LOAD;
            col_ready_reg  <= 1'b1;
            knl_loaded_reg <= 1'b0;
            load_cnt_reg   <= '0;
          end else if (i_en_conv && knl_loaded_reg) begin
            state_reg     <= RUN;
            col_ready_reg <= 1'b1;
            fill_reg      <= '0;
          end
        end
        LOAD: begin
          if (load_acc) begin
            if (load_cnt_reg == LW'(KS-1)) begin
              state_reg      <= IDLE;
              col_ready_reg  <= 1'b0;
              knl_loaded_reg <= 1'b1;
            end else begin
              load_cnt_reg <= load_cnt_reg + 1'b1;
            end
          end
        end
        RUN: begin
          if (run_acc)
            fill_reg <= fill_next;
          if (!i_en_conv) begin
            state_reg     <= IDLE;
            col_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          col_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Kernel element (r,c) lives at flat index r*KS+c; column c arrives as load beat c.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      knl_reg <= '0;
    end else if (load_acc) begin
      for (int r = 0; r < KS; r++)
        for (int c = 0; c < KS; c++)
          if (load_cnt_reg == LW'(c))
            knl_reg[(r*KS+c)*NB_COEFF +: NB_COEFF] <=
              NB_COEFF'($signed(i_col[r*NB_PIX +: NB_PIX]));
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      win_reg <= '0;
    end else if (run_acc) begin
      for (int r = 0; r < KS; r++) begin
        win_reg[r*KS*NB_PIX +: (KS-1)*NB_PIX] <= win_reg[(r*KS+1)*NB_PIX +: (KS-1)*NB_PIX];
        win_reg[(r*KS+KS-1)*NB_PIX +: NB_PIX] <= i_col[r*NB_PIX +: NB_PIX];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KS*KS; gi++) begin : g_mac
      logic signed [NB_PROD-1:0] prod_q;
      always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst)
          prod_q <= '0;
        else if (win_valid_reg)
          prod_q <= $signed(win_reg[gi*NB_PIX +: NB_PIX]) *
                    $signed(knl_reg[gi*NB_COEFF +: NB_COEFF]);
      end
      assign prod_flat[gi*NB_PROD +: NB_PROD] = prod_q;
    end
  endgenerate

  always_comb begin
    sum_acc = '0;
    for (int i = 0; i < KS*KS; i++)
      sum_acc = sum_acc + NB_ADD'($signed(prod_flat[i*NB_PROD +: NB_PROD]));
  end

  assign sum_ext = NB_W'(sum_acc);

  generate
    if (ROUND != 0 && D > 0) begin : g_round
      localparam logic [NB_W-1:0] HALF = NB_W'(1) << (D - 1);
      assign sum_rnd = sum_ext + $signed(HALF);
    end else begin : g_trunc
      assign sum_rnd = sum_ext;
    end
  endgenerate

  // Arithmetic shift floors toward -inf, which also gives truncation when ROUND=0.
  assign sum_shift = sum_rnd >>> D;

  always_comb begin
    sat_val = sum_shift[NB_OUT-1:0];
    if (sum_shift > MAX_OUT)
      sat_val = MAX_OUT[NB_OUT-1:0];
    else if (sum_shift < MIN_OUT)
      sat_val = MIN_OUT[NB_OUT-1:0];
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      win_valid_reg  <= 1'b0;
      prod_valid_reg <= 1'b0;
      valid_reg      <= 1'b0;
      pixel_reg      <= '0;
    end else begin
      win_valid_reg  <= win_done;
      prod_valid_reg <= win_valid_reg;
      valid_reg      <= prod_valid_reg;
      if (prod_valid_reg)
        pixel_reg <= sat_val;
    end
  end

  assign o_col_ready  = col_ready_reg;
  assign o_knl_loaded = knl_loaded_reg;
  assign o_pixel      = pixel_reg;
  assign o_valid      = valid_reg;

endmodule

// File: tb/tb_conv2d_kxk_engine.sv
// Bench for conv2d_kxk_engine: a rounding and a truncating instance share stimulus and are
// compared against a window/arithmetic reference model.
module tb_conv2d_kxk_engine;
  localparam int KS = 3;
  localparam int D  = 7;

  logic        clk = 1'b0;
  logic        nrst, load_knl, en_conv, line_start, col_valid;
  logic [23:0] col;
  logic        ready1, loaded1, valid1, ready0, loaded0, valid0;
  logic [7:0]  pix1, pix0;

  always #5 clk = ~clk;

  conv2d_kxk_engine #(.ROUND(1)) u_dut_rnd (
    .clk(clk), .i_nrst(nrst), .i_load_knl(load_knl), .i_en_conv(en_conv),
    .i_line_start(line_start), .i_col_valid(col_valid), .o_col_ready(ready1),
    .i_col(col), .o_knl_loaded(loaded1), .o_pixel(pix1), .o_valid(valid1));

  conv2d_kxk_engine #(.ROUND(0)) u_dut_trn (
    .clk(clk), .i_nrst(nrst), .i_load_knl(load_knl), .i_en_conv(en_conv),
    .i_line_start(line_start), .i_col_valid(col_valid), .o_col_ready(ready0),
    .i_col(col), .o_knl_loaded(loaded0), .o_pixel(pix0), .o_valid(valid0));

  int checks = 0;
  int errors = 0;

  logic [7:0]  obs1[$], obs0[$], exp1[$], exp0[$];
  logic [23:0] hist[$];
  int          base1 = 0, base0 = 0;
  int          knl_m[KS][KS];

  always @(negedge clk) begin
    if (valid1 === 1'b1) obs1.push_back(pix1);
    if (valid0 === 1'b1) obs0.push_back(pix0);
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [23:0] colv(input logic [7:0] top, input logic [7:0] mid, input logic [7:0] bot);
    return {bot, mid, top};
  endfunction

  // Reference: the last KS accepted columns since the line start form the window.
  task automatic model_col(input logic [23:0] c, input bit ls);
    int sum;
    logic [23:0] w;
    logic signed [7:0] p;
    if (ls) hist.delete();
    hist.push_back(c);
    if (hist.size() > KS) void'(hist.pop_front());
    if (hist.size() == KS) begin
      sum = 0;
      for (int r = 0; r < KS; r++)
        for (int cc = 0; cc < KS; cc++) begin
          w = hist[cc];
          p = w[r*8 +: 8];
          sum += int'(p) * knl_m[r][cc];
        end
      exp1.push_back(8'(sat8((sum + (1 << (D-1))) >>> D)));
      exp0.push_back(8'(sat8(sum >>> D)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input logic [23:0] c, input bit ls);
    col = c;
    line_start = ls;
    col_valid = 1'b1;
    chk("ready_in_run", 32'(ready1), 32'd1);
    tick();
    model_col(c, ls);
    col_valid = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic load_kernel(input bit with_en);
    load_knl = 1'b1;
    en_conv = with_en;
    tick();
    load_knl = 1'b0;
    en_conv = 1'b0;
    chk("load_entered_loaded_low", 32'(loaded1), 32'd0);
    chk("load_ready", 32'(ready1), 32'd1);
    for (int c = 0; c < KS; c++) begin
      for (int r = 0; r < KS; r++) col[r*8 +: 8] = 8'(knl_m[r][c]);
      col_valid = 1'b1;
      tick();
    end
    col_valid = 1'b0;
    chk("kernel_loaded", 32'(loaded1), 32'd1);
    chk("load_done_not_ready", 32'(ready1), 32'd0);
  endtask

  task automatic start_run();
    en_conv = 1'b1;
    tick();
    chk("run_ready", 32'(ready1), 32'd1);
    hist.delete();
  endtask

  task automatic stop_run();
    en_conv = 1'b0;
    tick();
    chk("stop_not_ready", 32'(ready1), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n1, n0;
    repeat (5) tick();
    n1 = obs1.size() - base1;
    n0 = obs0.size() - base0;
    chk({tag, "_count_rnd"}, 32'(n1), 32'(exp1.size()));
    chk({tag, "_count_trn"}, 32'(n0), 32'(exp0.size()));
    for (int i = 0; i < n1 && i < exp1.size(); i++)
      chk({tag, "_pix_rnd"}, 32'(obs1[base1+i]), 32'(exp1[i]));
    for (int i = 0; i < n0 && i < exp0.size(); i++)
      chk({tag, "_pix_trn"}, 32'(obs0[base0+i]), 32'(exp0[i]));
    base1 = obs1.size();
    base0 = obs0.size();
    exp1.delete();
    exp0.delete();
  endtask

  task automatic set_kernel_const(input int centre, input int other);
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++)
        knl_m[r][c] = (r == 1 && c == 1) ? centre : other;
  endtask

  task automatic set_kernel_rand();
    logic signed [7:0] t;
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) begin
        t = 8'($urandom());
        knl_m[r][c] = t;
      end
  endtask

  logic [23:0] seq_col[12];
  bit          seq_ls[12];
  logic [7:0]  ref_out[$];
  int          b, n;

  initial begin
    nrst = 1'b0; load_knl = 1'b0; en_conv = 1'b0; line_start = 1'b0;
    col_valid = 1'b0; col = '0;
    #12;
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_pixel", 32'(pix1), 32'd0);
    chk("rst_ready", 32'(ready1), 32'd0);
    chk("rst_loaded", 32'(loaded1), 32'd0);
    nrst = 1'b1;
    tick();
    en_conv = 1'b1;
    tick(); tick();
    chk("en_without_kernel_idle", 32'(ready1), 32'd0);
    en_conv = 1'b0;

    // Basic convolution with latency check
    set_kernel_const(64, 0);
    load_kernel(1'b0);
    start_run();
    send_col(24'h404040, 1'b0);
    send_col(24'h404040, 1'b0);
    send_col(24'h404040, 1'b0);
    chk("lat_edge_n", 32'(valid1), 32'd0);
    tick();
    chk("lat_edge_n1", 32'(valid1), 32'd0);
    tick();
    chk("lat_edge_n2_valid", 32'(valid1), 32'd1);
    chk("lat_edge_n2_pixel", 32'(pix1), 32'h20);
    for (int i = 0; i < 4; i++) send_col(24'h404040, 1'b0);
    drain("basic");
    stop_run();

    // Saturation both ways
    set_kernel_const(127, 127);
    load_kernel(1'b0);
    start_run();
    for (int i = 0; i < 3; i++) send_col(24'h7F7F7F, 1'b0);
    for (int i = 0; i < 3; i++) send_col(24'h808080, 1'b0);
    drain("sat");
    if (obs1.size() >= 4) begin
      chk("sat_pos", 32'(obs1[obs1.size()-4]), 32'h7F);
      chk("sat_neg", 32'(obs1[obs1.size()-1]), 32'h80);
    end
    stop_run();

    // Rounding vs truncation; load requested together with enable
    set_kernel_const(64, 0);
    load_kernel(1'b1);
    start_run();
    send_col(24'h0, 1'b0);
    send_col(colv(8'h00, 8'h01, 8'h00), 1'b0);
    send_col(24'h0, 1'b0);
    send_col(24'h0, 1'b1);
    send_col(colv(8'h00, 8'hFF, 8'h00), 1'b0);
    send_col(24'h0, 1'b0);
    drain("round");
    if (obs1.size() >= 2 && obs0.size() >= 2) begin
      chk("round_pos_rnd", 32'(obs1[obs1.size()-2]), 32'h01);
      chk("round_pos_trn", 32'(obs0[obs0.size()-2]), 32'h00);
      chk("round_neg_rnd", 32'(obs1[obs1.size()-1]), 32'h00);
      chk("round_neg_trn", 32'(obs0[obs0.size()-1]), 32'hFF);
    end

    // Line restart on the 5th column
    b = base1;
    for (int i = 0; i < 7; i++) send_col(24'($urandom()), (i == 0 || i == 4));
    drain("restart");
    chk("restart_count", 32'(base1 - b), 32'd3);

    // Drop enable together with the last column
    send_col(24'($urandom()), 1'b1);
    send_col(24'($urandom()), 1'b0);
    send_col(24'($urandom()), 1'b0);
    col = 24'($urandom());
    col_valid = 1'b1;
    en_conv = 1'b0;
    tick();
    model_col(col, 1'b0);
    col_valid = 1'b0;
    chk("ready_after_stop", 32'(ready1), 32'd0);
    drain("stop_inflight");

    // Gap-free vs gapped runs of the same column sequence
    set_kernel_rand();
    load_kernel(1'b0);
    start_run();
    for (int i = 0; i < 12; i++) begin
      seq_col[i] = 24'($urandom());
      seq_ls[i] = (i == 0) || ($urandom_range(0, 5) == 0);
    end
    b = base1;
    for (int i = 0; i < 12; i++) send_col(seq_col[i], seq_ls[i]);
    drain("nogap");
    for (int i = b; i < base1; i++) ref_out.push_back(obs1[i]);
    b = base1;
    for (int i = 0; i < 12; i++) begin
      send_col(seq_col[i], seq_ls[i]);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("gap");
    chk("gap_count_same", 32'(base1 - b), 32'(ref_out.size()));
    n = base1 - b;
    for (int i = 0; i < n && i < ref_out.size(); i++)
      chk("gap_seq_same", 32'(obs1[b+i]), 32'(ref_out[i]));
    stop_run();

    // Random kernels and streams
    for (int k = 0; k < 3; k++) begin
      set_kernel_rand();
      load_kernel(1'(k & 1));
      start_run();
      for (int i = 0; i < 15; i++) begin
        send_col(24'($urandom()), (i == 0) || ($urandom_range(0, 7) == 0));
        repeat ($urandom_range(0, 2)) tick();
      end
      drain("random");
      stop_run();
    end

    // Asynchronous reset in the middle of a run
    start_run();
    for (int i = 0; i < 5; i++) send_col(24'($urandom()), (i == 0));
    chk("pre_reset_valid", 32'(valid1), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid1), 32'd0);
    chk("async_rst_pixel", 32'(pix1), 32'd0);
    chk("async_rst_ready", 32'(ready1), 32'd0);
    chk("async_rst_loaded", 32'(loaded1), 32'd0);
    chk("async_rst_valid_trn", 32'(valid0), 32'd0);
    tick();
    base1 = obs1.size();
    base0 = obs0.size();
    exp1.delete();
    exp0.delete();
    nrst = 1'b1;
    tick(); tick();
    chk("post_rst_idle_ready", 32'(ready1), 32'd0);
    chk("post_rst_idle_loaded", 32'(loaded1), 32'd0);
    en_conv = 1'b0;
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
